// File: rtl/kbd_key_sequencer.sv
// PS/2 scan-code parser that turns 16 letter keys into a letter FIFO plus a held-key map.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses auto-repeat pushes for keys already held.
module kbd_key_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  code_in,
  input  logic        code_valid,
  output logic [4:0]  letter,
  output logic        letter_valid,
  input  logic        letter_ready,
  output logic [15:0] held,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [1:0]  seq_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Returns {hit, letter index}; hit is 0 for every unmapped code.
  function automatic logic [4:0] map_code(input logic [7:0] code);
    case (code)
      8'h1C:   map_code = {1'b1, 4'd0};
      8'h32:   map_code = {1'b1, 4'd1};
      8'h21:   map_code = {1'b1, 4'd2};
      8'h23:   map_code = {1'b1, 4'd3};
      8'h24:   map_code = {1'b1, 4'd4};
      8'h2B:   map_code = {1'b1, 4'd5};
      8'h34:   map_code = {1'b1, 4'd6};
      8'h33:   map_code = {1'b1, 4'd7};
      8'h3B:   map_code = {1'b1, 4'd8};
      8'h4B:   map_code = {1'b1, 4'd9};
      8'h31:   map_code = {1'b1, 4'd10};
      8'h44:   map_code = {1'b1, 4'd11};
      8'h4D:   map_code = {1'b1, 4'd12};
      8'h2D:   map_code = {1'b1, 4'd13};
      8'h1B:   map_code = {1'b1, 4'd14};
      8'h35:   map_code = {1'b1, 4'd15};
      default: map_code = 5'd0;
    endcase
  endfunction

  state_t          r_state;
  logic [15:0]     r_held;
  logic            r_overflow;
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [4:0]      r_letter;
  logic            r_letter_valid;

  logic [4:0]      w_map;
  logic            w_mapped;
  logic [3:0]      w_idx;
  logic            w_push_req;
  logic            w_pop;
  logic            w_full;
  logic            w_push_ok;
  logic            w_ovf_evt;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [CW-1:0]   w_count_after_pop;
  logic [CW-1:0]   w_count_nxt;
  logic [4:0]      w_head_nxt;

  // Decode the incoming byte and work out this cycle's FIFO movement and next head.
  always_comb begin
    w_map    = map_code(code_in);
    w_mapped = w_map[4];
    w_idx    = w_map[3:0];
`ifdef KBD_TYPEMATIC_FILTER_EN
    w_push_req = code_valid && (r_state == ST_IDLE) && w_mapped && !r_held[w_idx];
`else
    w_push_req = code_valid && (r_state == ST_IDLE) && w_mapped;
`endif
    w_pop     = r_letter_valid && letter_ready;
    w_full    = (r_count == CW'(FIFO_DEPTH));
    w_push_ok = w_push_req && (!w_full || w_pop);
    w_ovf_evt = w_push_req && w_full && !w_pop;

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_count_after_pop = r_count - CW'(w_pop);
    w_count_nxt       = w_count_after_pop + CW'(w_push_ok);

    // A push into an emptied queue becomes the head directly; memory is not yet written.
    if (w_count_nxt == CW'(0)) begin
      w_head_nxt = 5'd16;
    end else if (w_count_after_pop == CW'(0)) begin
      w_head_nxt = {1'b0, w_idx};
    end else begin
      w_head_nxt = {1'b0, r_mem[w_rd_ptr_nxt]};
    end
  end

  // Prefix parser and held-key map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_held  <= 16'd0;
    end else if (code_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (code_in == 8'hF0) begin
            r_state <= ST_BRK;
          end else if (code_in == 8'hE0) begin
            r_state <= ST_EXT;
          end else begin
            r_state <= ST_IDLE;
            if (w_mapped) begin
              r_held[w_idx] <= 1'b1;
            end
          end
        end
        ST_BRK: begin
          r_state <= ST_IDLE;
          if (w_mapped) begin
            r_held[w_idx] <= 1'b0;
          end
        end
        ST_EXT: begin
          r_state <= (code_in == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Letter FIFO, registered head outputs and sticky overflow (a new drop beats a clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 4'd0;
      end
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_letter       <= 5'd16;
      r_letter_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_idx;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_letter       <= w_head_nxt;
      r_letter_valid <= (w_count_nxt != CW'(0));
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign letter       = r_letter;
  assign letter_valid = r_letter_valid;
  assign held         = r_held;
  assign overflow     = r_overflow;
  assign seq_state    = r_state;

endmodule

// File: tb/tb_kbd_key_sequencer.sv
// Directed self-checking bench for kbd_key_sequencer (FIFO_DEPTH = 4).
module tb_kbd_key_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  code_in;
  logic        code_valid;
  logic [4:0]  letter;
  logic        letter_valid;
  logic        letter_ready;
  logic [15:0] held;
  logic        overflow;
  logic        clr_ovf;
  logic [1:0]  seq_state;

  int n_tests = 0;
  int n_fail  = 0;

  kbd_key_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .held         (held),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic release_key(input logic [7:0] b);
    send_byte(8'hF0);
    send_byte(b);
  endtask

  logic [7:0] codes [5];
  int         n_out;
  int         exp_typ;

  initial begin
    codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23; codes[4] = 8'h24;
    rst = 1'b1; code_in = 8'h00; code_valid = 1'b0; letter_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check_eq("rst_letter", 32'(letter), 32'd16);
    check_eq("rst_valid", 32'(letter_valid), 32'd0);
    check_eq("rst_held", 32'(held), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_state", 32'(seq_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Make then break of key 1C
    send_byte(8'h1C);
    check_eq("mk_letter", 32'(letter), 32'd0);
    check_eq("mk_valid", 32'(letter_valid), 32'd1);
    check_eq("mk_held", 32'(held), 32'h0001);
    send_byte(8'hF0);
    check_eq("brk_state", 32'(seq_state), 32'd1);
    send_byte(8'h1C);
    check_eq("brk_held", 32'(held), 32'h0000);
    check_eq("brk_state0", 32'(seq_state), 32'd0);
    check_eq("brk_letter", 32'(letter), 32'd0);
    @(negedge clk); letter_ready = 1'b1;
    @(negedge clk); letter_ready = 1'b0;
    check_eq("pop_empty_letter", 32'(letter), 32'd16);
    check_eq("pop_empty_valid", 32'(letter_valid), 32'd0);

    // Extended make and extended break are ignored
    send_byte(8'hE0);
    check_eq("ext_state", 32'(seq_state), 32'd2);
    send_byte(8'h1C);
    check_eq("ext_ret", 32'(seq_state), 32'd0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check_eq("extbrk_state", 32'(seq_state), 32'd3);
    send_byte(8'h1C);
    check_eq("extbrk_ret", 32'(seq_state), 32'd0);
    check_eq("ext_valid", 32'(letter_valid), 32'd0);
    check_eq("ext_held", 32'(held), 32'd0);

    // Overflow on the fifth push with no consumer
    for (int i = 0; i < 5; i++) send_byte(codes[i]);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_head", 32'(letter), 32'd0);
    check_eq("ovf_held", 32'(held), 32'h001F);
    @(negedge clk); letter_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_order", 32'(letter), 32'(i));
      @(negedge clk);
    end
    letter_ready = 1'b0;
    check_eq("drain_empty", 32'(letter), 32'd16);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    check_eq("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) release_key(codes[i]);
    check_eq("release_held", 32'(held), 32'd0);

    // Full FIFO: drop with clear in the same cycle, then push plus pop
    send_byte(8'h2B); send_byte(8'h34); send_byte(8'h33); send_byte(8'h3B);
    @(negedge clk);
    code_in = 8'h4B; code_valid = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; clr_ovf = 1'b0;
    check_eq("ovf_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    code_in = 8'h35; code_valid = 1'b1; letter_ready = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; letter_ready = 1'b0;
    check_eq("full_pushpop_ovf", 32'(overflow), 32'd0);
    check_eq("full_pushpop_head", 32'(letter), 32'd6);
    letter_ready = 1'b1;
    check_eq("fp_order6", 32'(letter), 32'd6); @(negedge clk);
    check_eq("fp_order7", 32'(letter), 32'd7); @(negedge clk);
    check_eq("fp_order8", 32'(letter), 32'd8); @(negedge clk);
    check_eq("fp_order15", 32'(letter), 32'd15); @(negedge clk);
    letter_ready = 1'b0;
    check_eq("fp_empty", 32'(letter), 32'd16);

    // Auto-repeat of a held key
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
`ifdef KBD_TYPEMATIC_FILTER_EN
    exp_typ = 1;
`else
    exp_typ = 3;
`endif
    n_out = 0;
    @(negedge clk); letter_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (letter_valid) begin
        n_out++;
        check_eq("typ_letter", 32'(letter), 32'd0);
      end
      @(negedge clk);
    end
    letter_ready = 1'b0;
    check_eq("typ_count", 32'(n_out), 32'(exp_typ));
    release_key(8'h1C);

    // Reset in the middle of a break prefix
    send_byte(8'hF0);
    check_eq("pre_rst_state", 32'(seq_state), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_state", 32'(seq_state), 32'd0);
    check_eq("mid_rst_held", 32'(held), 32'd0);
    check_eq("mid_rst_letter", 32'(letter), 32'd16);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h32);
    check_eq("post_rst_letter", 32'(letter), 32'd1);
    check_eq("post_rst_held", 32'(held), 32'h0002);
    check_eq("post_rst_state", 32'(seq_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
